modn_updown_ctr: RTL and testbench
==================================

# modn_updown_ctr

Runtime-programmable modulo-M up/down counter with synchronous load, registered terminal-count pulse and a one-shot mode driven by a small state machine. It is the next-generation counter primitive for timers, digit chains and frame/strobe generation across the design. It replaces fixed-modulus counters where the modulus, direction or run mode must change without re-synthesis. Stages cascade by feeding `cnt_max` into the next stage's `enb`.

## Interface
- `WIDTH`, 8: counter, modulus and load width.
- `DEFAULT_MOD`, 10: modulus used when `mod_val` = 0; must satisfy 2 ≤ DEFAULT_MOD ≤ 2^WIDTH−1.
- `PRESC_W`, 4: prescaler width; used only when `MODN_CTR_PRESCALE_EN` is defined.

Ports (clock and reset first):
- `clk`  in  1  clock; all state changes on the rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `enb`  in  1  count enable (step qualifier).
- `up`  in  1  direction: 1 = increment, 0 = decrement.
- `mod_val`  in  WIDTH  runtime modulus M; 0 selects DEFAULT_MOD.
- `load`  in  1  synchronous load strobe.
- `load_val`  in  WIDTH  value written on `load`.
- `oneshot`  in  1  1 = one-shot mode, 0 = free-running.
- `start`  in  1  one-shot trigger pulse.
- `presc_div`  in  PRESC_W  prescale divisor minus one; present only with the macro.
- `out`  out  WIDTH  counter value, always in 0..M−1 after any step or load.
- `cnt_max`  out  1  one-cycle pulse on each wrap step.
- `busy`  out  1  high while the one-shot FSM is in RUN.

## Operation
- Effective modulus: M = DEFAULT_MOD if `mod_val` = 0, else `mod_val`. M = 1 is legal: `out` stays 0 and every step is a wrap.
- Step: `step` = `enb` & `tick` & (`oneshot` ? state==RUN : 1). `tick` = 1 without the macro.
- Up step: `out` ≥ M−1 → 0 (wrap); else `out`+1.
- Down step: `out` = 0 → M−1 (wrap); `out` ≥ M → M−1 (no wrap); else `out`−1.
- A wrap step sets `cnt_max` = 1 for exactly one cycle; otherwise `cnt_max` = 0.
- Load: `load` = 1 → `out` ← min(`load_val`, M−1). Load has priority over a step in the same cycle. Load never raises `cnt_max` and never changes FSM state.
- A change of `mod_val` takes effect on the next cycle; out-of-range `out` is corrected only by the next step, per the rules above.
- One-shot FSM:
  - IDLE: `busy` = 0. `start` & `oneshot` → RUN.
  - RUN: `busy` = 1. Counts on `step`. Wrap step → DONE.
  - DONE: `busy` = 0, `out` holds the wrapped value. Unconditionally → IDLE after one cycle.
  - `start` is ignored in RUN and DONE.
- `oneshot` = 0 forces the FSM to IDLE on the next edge; free-run counting is unaffected by FSM state.

## Timing
- Reset (`rstn` = 0 at an edge) forces `out` = 0, `cnt_max` = 0, `busy` = 0, state = IDLE, prescaler = 0. Reset overrides `load`, `start` and `step`.
- Reset mid-RUN aborts the one-shot with no `cnt_max` pulse.
- A step sampled at edge k is visible on `out` after edge k; `cnt_max` rises after the same edge, coincident with the wrapped value.
- `start` sampled at edge k → `busy` = 1 after edge k. The first count can occur at edge k+1.
- The wrap step at edge j in RUN → `busy` falls and `cnt_max` rises after edge j; the state returns to IDLE after edge j+1.
- `start` in the DONE cycle is dropped; a new `start` is accepted at IDLE.

## Configuration
- `MODN_CTR_PRESCALE_EN` defined:
  - Adds port `presc_div` and a PRESC_W-bit prescaler that advances on each `enb` cycle.
  - `tick` = 1 when the prescaler equals `presc_div`; the prescaler then clears to 0. Steps therefore occur every (`presc_div`+1) enabled cycles; `presc_div` = 0 gives a step every enabled cycle.
  - `load` and reset clear the prescaler.
- `MODN_CTR_PRESCALE_EN` undefined:
  - No prescaler logic and no `presc_div` port; `tick` = 1.

## Test plan
- Free-run up, `mod_val` = 0 (DEFAULT_MOD 10), `enb` = 1 for 25 cycles → `out` sequence 0..9,0..9,0..4; `cnt_max` high exactly on the two cycles where `out` = 0 after 9.
- Down count, `mod_val` = 5, `load` with `load_val` = 200 → `out` = 4. Then 5 steps → 3,2,1,0,4, with `cnt_max` only on the 0→4 step.
- `load` and `enb` in the same cycle with `out` = 9, `load_val` = 3 → `out` = 3, `cnt_max` = 0.
- One-shot, M = 4, up: `start` pulse → `busy` = 1, `out` 1,2,3,0. `busy` and `cnt_max` change after the wrap edge, and the counter then holds at 0. A `start` during RUN has no effect.
- `rstn` = 0 mid-RUN with `out` = 2 → next cycle `out` = 0, `busy` = 0, `cnt_max` = 0, state IDLE.
- With `MODN_CTR_PRESCALE_EN`, `presc_div` = 2, `enb` = 1 → `out` increments every 3rd cycle. `enb` low cycles do not advance the prescaler.

Source files
------------

// File: rtl/modn_updown_ctr_if.sv
// ---------------------------------------------------------------------------
// modn_updown_ctr_if
// Signal bundle for the modulo-M up/down counter (everything except clk/rstn).
//
// master modport (the user of the counter):
//   drives  enb, up, mod_val, load, load_val, oneshot, start
//           (and presc_div when MODN_CTR_PRESCALE_EN is defined)
//   reads   out, cnt_max, busy
// slave modport (the counter itself): the opposite directions.
//
// Optional feature macro: MODN_CTR_PRESCALE_EN adds presc_div.
// ---------------------------------------------------------------------------
interface modn_updown_ctr_if #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
);
    logic             enb;
    logic             up;
    logic [WIDTH-1:0] mod_val;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             oneshot;
    logic             start;
`ifdef MODN_CTR_PRESCALE_EN
    logic [PRESC_W-1:0] presc_div;
`else
    // Keeps the prescaler width parameter referenced in the default build.
    logic [PRESC_W-1:0] unused_presc_w;
    assign unused_presc_w = '0;
`endif
    logic [WIDTH-1:0] out;
    logic             cnt_max;
    logic             busy;

    modport master (
`ifdef MODN_CTR_PRESCALE_EN
        output presc_div,
`endif
        output enb, up, mod_val, load, load_val, oneshot, start,
        input  out, cnt_max, busy
    );

    modport slave (
`ifdef MODN_CTR_PRESCALE_EN
        input  presc_div,
`endif
        input  enb, up, mod_val, load, load_val, oneshot, start,
        output out, cnt_max, busy
    );
endinterface

// File: rtl/modn_updown_ctr.sv
// ---------------------------------------------------------------------------
// modn_updown_ctr
// Runtime-programmable modulo-M up/down counter with synchronous load,
// registered terminal-count pulse and a one-shot run mode.
//
// Parameters:
//   WIDTH       counter / modulus / load width
//   DEFAULT_MOD modulus used when mod_val == 0 (2 .. 2^WIDTH-1)
//   PRESC_W     prescaler width (only with MODN_CTR_PRESCALE_EN)
//
// Ports:
//   clk      clock, rising edge
//   rstn     synchronous active-low reset
//   bus      modn_updown_ctr_if.slave:
//              enb, up, mod_val, load, load_val, oneshot, start,
//              [presc_div], out, cnt_max, busy
//
// Optional feature macro: MODN_CTR_PRESCALE_EN enables the step prescaler.
// Cascading: feed cnt_max of one stage into enb of the next.
// ---------------------------------------------------------------------------
module modn_updown_ctr #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_MOD = 10,
    parameter int PRESC_W     = 4
) (
    input  logic              clk,
    input  logic              rstn,
    modn_updown_ctr_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] DEF_MOD = WIDTH'(DEFAULT_MOD);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             cnt_max_q, cnt_max_d;

    logic [WIDTH-1:0] eff_mod;
    logic [WIDTH-1:0] top_val;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] stepped_val;
    logic             wrap;
    logic             tick;
    logic             step;
    logic             do_step;

`ifdef MODN_CTR_PRESCALE_EN
    logic [PRESC_W-1:0] presc_q;

    // Prescaler advances on every enabled cycle, independent of run mode,
    // and restarts on load so a reloaded count gets a full prescale period.
    assign tick = (presc_q == bus.presc_div);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            presc_q <= '0;
        end else if (bus.load) begin
            presc_q <= '0;
        end else if (bus.enb) begin
            presc_q <= tick ? '0 : presc_q + PRESC_W'(1);
        end
    end
`else
    logic [PRESC_W-1:0] unused_presc_w;
    assign unused_presc_w = '0;
    assign tick           = 1'b1;
`endif

    // Datapath: effective modulus, clamped load value and the value one
    // step away in the current direction. An out-of-range count (left over
    // after mod_val shrank) snaps to M-1 on a down step without a wrap.
    always_comb begin
        eff_mod      = (bus.mod_val == '0) ? DEF_MOD : bus.mod_val;
        top_val      = eff_mod - WIDTH'(1);
        load_clamped = (bus.load_val > top_val) ? top_val : bus.load_val;
        stepped_val  = cnt_q;
        wrap         = 1'b0;
        if (bus.up) begin
            if (cnt_q >= top_val) begin
                stepped_val = '0;
                wrap        = 1'b1;
            end else begin
                stepped_val = cnt_q + WIDTH'(1);
            end
        end else begin
            if (cnt_q == '0) begin
                stepped_val = top_val;
                wrap        = 1'b1;
            end else if (cnt_q >= eff_mod) begin
                stepped_val = top_val;
            end else begin
                stepped_val = cnt_q - WIDTH'(1);
            end
        end
    end

    // A step is suppressed by load, so load can neither pulse cnt_max nor
    // push the one-shot FSM out of RUN.
    assign step    = bus.enb & tick & (bus.oneshot ? (state_q == RUN) : 1'b1);
    assign do_step = step & ~bus.load;

    always_comb begin
        cnt_d     = cnt_q;
        cnt_max_d = 1'b0;
        if (bus.load) begin
            cnt_d = load_clamped;
        end else if (step) begin
            cnt_d     = stepped_val;
            cnt_max_d = wrap;
        end
    end

    // One-shot FSM next state; leaving one-shot mode always returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (!bus.oneshot) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.start) state_d = RUN;
                RUN:     if (do_step && wrap) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cnt_max_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cnt_max_q <= cnt_max_d;
        end
    end

    assign bus.out     = cnt_q;
    assign bus.cnt_max = cnt_max_q;
    assign bus.busy    = (state_q == RUN);

endmodule

// File: tb/tb_modn_updown_ctr.sv
// ---------------------------------------------------------------------------
// tb_modn_updown_ctr
// Self-checking bench for modn_updown_ctr: directed scenarios followed by
// randomized stimulus, compared against a behavioural reference model.
// Honours MODN_CTR_PRESCALE_EN when the build defines it.
// ---------------------------------------------------------------------------
module tb_modn_updown_ctr;

    localparam int WIDTH   = 8;
    localparam int DEF_MOD = 10;
    localparam int PRESC_W = 4;

    localparam int PH_IDLE = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_DONE = 2;

    logic clk;
    logic rstn;

    modn_updown_ctr_if #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) bus ();

    modn_updown_ctr #(
        .WIDTH(WIDTH),
        .DEFAULT_MOD(DEF_MOD),
        .PRESC_W(PRESC_W)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_count  = 0;
    int miscompare = 0;

    // Reference model state
    int exp_out   = 0;
    int exp_cmax  = 0;
    int exp_phase = PH_IDLE;
    int exp_presc = 0;
    int presc_div_val = 0;

    // Per-scenario counters
    int wraps;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        vec_count++;
        if (actual != expected) begin
            miscompare++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Advances the reference model by one clock edge using the inputs
    // currently driven.
    task automatic modelStep();
        int  m;
        bit  tick;
        bit  active;
        bit  stepping;
        bit  wrapped;
        m = (int'(bus.mod_val) == 0) ? DEF_MOD : int'(bus.mod_val);
        if (!rstn) begin
            exp_out   = 0;
            exp_cmax  = 0;
            exp_phase = PH_IDLE;
            exp_presc = 0;
            return;
        end
        tick = 1'b1;
`ifdef MODN_CTR_PRESCALE_EN
        tick = (exp_presc == presc_div_val);
        if (bus.load)
            exp_presc = 0;
        else if (bus.enb)
            exp_presc = tick ? 0 : (exp_presc + 1) % (1 << PRESC_W);
`endif
        active   = !bus.oneshot || (exp_phase == PH_RUN);
        stepping = bus.enb && tick && active && !bus.load;
        wrapped  = 1'b0;
        if (bus.load) begin
            exp_out = (int'(bus.load_val) < m - 1) ? int'(bus.load_val) : m - 1;
        end else if (stepping) begin
            if (bus.up) begin
                if (exp_out >= m - 1) begin
                    exp_out = 0;
                    wrapped = 1'b1;
                end else begin
                    exp_out = exp_out + 1;
                end
            end else begin
                if (exp_out == 0) begin
                    exp_out = m - 1;
                    wrapped = 1'b1;
                end else if (exp_out >= m) begin
                    exp_out = m - 1;
                end else begin
                    exp_out = exp_out - 1;
                end
            end
        end
        exp_cmax = wrapped ? 1 : 0;
        if (!bus.oneshot)
            exp_phase = PH_IDLE;
        else if (exp_phase == PH_IDLE)
            exp_phase = bus.start ? PH_RUN : PH_IDLE;
        else if (exp_phase == PH_RUN)
            exp_phase = wrapped ? PH_DONE : PH_RUN;
        else
            exp_phase = PH_IDLE;
    endtask

    // Drives one cycle of inputs, clocks it, then compares all outputs.
    task automatic applyStimulus(input int r, input int e, input int u, input int mv,
                                 input int ld, input int lv, input int os, input int st);
        rstn         = r[0];
        bus.enb      = e[0];
        bus.up       = u[0];
        bus.mod_val  = WIDTH'(mv);
        bus.load     = ld[0];
        bus.load_val = WIDTH'(lv);
        bus.oneshot  = os[0];
        bus.start    = st[0];
`ifdef MODN_CTR_PRESCALE_EN
        bus.presc_div = PRESC_W'(presc_div_val);
`endif
        modelStep();
        @(posedge clk);
        #1;
        checkOutput("out", int'(bus.out), exp_out);
        checkOutput("cnt_max", int'(bus.cnt_max), exp_cmax);
        checkOutput("busy", int'(bus.busy), (exp_phase == PH_RUN) ? 1 : 0);
        if (bus.cnt_max) wraps++;
    endtask

    initial begin
        int r, e, u, mv, ld, lv, os, st;

        rstn = 1'b0;
        bus.enb = 1'b0; bus.up = 1'b1; bus.mod_val = '0; bus.load = 1'b0;
        bus.load_val = '0; bus.oneshot = 1'b0; bus.start = 1'b0;
`ifdef MODN_CTR_PRESCALE_EN
        bus.presc_div = '0;
`endif
        #2;

        // Reset state
        applyStimulus(0, 1, 1, 0, 1, 7, 1, 1);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("reset_out", int'(bus.out), 0);
        checkOutput("reset_busy", int'(bus.busy), 0);

        // Free-run up, default modulus, 25 steps: two wraps, ends at 5
        wraps = 0;
        for (int i = 0; i < 25; i++) applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
        checkOutput("freerun_wraps", wraps, 2);
        checkOutput("freerun_end", int'(bus.out), 5);

        // Down count, M=5, load 200 clamps to 4, then 3,2,1,0,4
        applyStimulus(1, 0, 0, 5, 1, 200, 0, 0);
        checkOutput("load_clamp", int'(bus.out), 4);
        wraps = 0;
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 5, 0, 0, 0, 0);
        checkOutput("down_wraps", wraps, 1);
        checkOutput("down_end", int'(bus.out), 4);

        // Load beats step: out=9, load 3 with enb -> 3, no pulse
        applyStimulus(1, 0, 1, 0, 1, 9, 0, 0);
        applyStimulus(1, 1, 1, 0, 1, 3, 0, 0);
        checkOutput("load_prio_out", int'(bus.out), 3);
        checkOutput("load_prio_cmax", int'(bus.cnt_max), 0);

        // M=1: every up step wraps and out stays 0
        wraps = 0;
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 1, 0, 0, 0, 0);
        checkOutput("m1_wraps", wraps, 3);

        // One-shot M=4 up, with a stray start during RUN
        applyStimulus(1, 0, 1, 4, 1, 0, 1, 0);
        applyStimulus(1, 1, 1, 4, 0, 0, 1, 1);
        checkOutput("os_busy_rise", int'(bus.busy), 1);
        checkOutput("os_first_hold", int'(bus.out), 0);
        wraps = 0;
        applyStimulus(1, 1, 1, 4, 0, 0, 1, 0);
        applyStimulus(1, 1, 1, 4, 0, 0, 1, 1);
        applyStimulus(1, 1, 1, 4, 0, 0, 1, 0);
        applyStimulus(1, 1, 1, 4, 0, 0, 1, 0);
        checkOutput("os_wrap_cmax", int'(bus.cnt_max), 1);
        checkOutput("os_wrap_busy", int'(bus.busy), 0);
        applyStimulus(1, 1, 1, 4, 0, 0, 1, 1);
        applyStimulus(1, 1, 1, 4, 0, 0, 1, 0);
        applyStimulus(1, 1, 1, 4, 0, 0, 1, 0);
        checkOutput("os_hold_out", int'(bus.out), 0);
        checkOutput("os_done_start_dropped", int'(bus.busy), 0);
        checkOutput("os_wraps", wraps, 1);

        // Reset mid-RUN at out=2 aborts with no pulse
        applyStimulus(1, 0, 1, 4, 0, 0, 1, 1);
        applyStimulus(1, 1, 1, 4, 0, 0, 1, 0);
        applyStimulus(1, 1, 1, 4, 0, 0, 1, 0);
        checkOutput("abort_pre_out", int'(bus.out), 2);
        applyStimulus(0, 1, 1, 4, 0, 0, 1, 0);
        checkOutput("abort_out", int'(bus.out), 0);
        checkOutput("abort_busy", int'(bus.busy), 0);
        checkOutput("abort_cmax", int'(bus.cnt_max), 0);

`ifdef MODN_CTR_PRESCALE_EN
        // Prescale by 3; enb-low cycles do not advance the prescaler
        presc_div_val = 2;
        applyStimulus(1, 0, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
        checkOutput("presc_six", int'(bus.out), 2);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
        checkOutput("presc_gap", int'(bus.out), 2);
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
        checkOutput("presc_resume", int'(bus.out), 3);
`endif

        // Randomized phase
        u = 1; mv = 0; os = 0;
        for (int i = 0; i < 2000; i++) begin
            r  = ($urandom_range(0, 99) != 0) ? 1 : 0;
            e  = ($urandom_range(0, 3) != 0) ? 1 : 0;
            if ($urandom_range(0, 19) == 0) u = 1 - u;
            if ($urandom_range(0, 29) == 0)
                mv = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255))
                                                 : int'($urandom_range(0, 12));
            ld = ($urandom_range(0, 19) == 0) ? 1 : 0;
            lv = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 12));
            if ($urandom_range(0, 49) == 0) os = 1 - os;
            st = ($urandom_range(0, 7) == 0) ? 1 : 0;
`ifdef MODN_CTR_PRESCALE_EN
            if ($urandom_range(0, 99) == 0) presc_div_val = int'($urandom_range(0, 3));
`endif
            applyStimulus(r, e, u, mv, ld, lv, os, st);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare);
        $finish;
    end

endmodule
